// File: rtl/head_ptr_fetch_if.sv
// Command/task stream types and the handshake bundle between the hash stage,
// the head-pointer fetch stage and the data-table engines.
package head_ptr_fetch_pkg;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int BUCKET_WIDTH     = 8;
  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;

  typedef struct packed {
    logic [1:0]             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t                 cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_pdata_t;
endpackage

interface head_ptr_fetch_if;
  import head_ptr_fetch_pkg::*;

  ht_command_t             cmd;
  logic [BUCKET_WIDTH-1:0] bucket;
  logic                    cmd_valid;
  logic                    cmd_ready;
  ht_pdata_t               task_data;
  logic                    task_valid;
  logic                    task_ready;

  modport master (
    output cmd, bucket, cmd_valid, task_ready,
    input  cmd_ready, task_data, task_valid
  );

  modport slave (
    input  cmd, bucket, cmd_valid, task_ready,
    output cmd_ready, task_data, task_valid
  );
endinterface

// File: rtl/head_ptr_fetch.sv
// Head-table lookup stage: issues a head-table read per command, aligns the
// RAM data with the command, forwards engine writes, and buffers tasks.
module head_ptr_fetch
  import head_ptr_fetch_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int B_WIDTH     = BUCKET_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  head_ptr_fetch_if.slave    hp_if,
  output logic [B_WIDTH-1:0] ht_rd_addr_o,
  output logic               ht_rd_en_o,
  input  logic [A_WIDTH-1:0] ht_rd_ptr_i,
  input  logic               ht_rd_ptr_val_i,
  input  logic               snoop_wr_en_i,
  input  logic [B_WIDTH-1:0] snoop_wr_addr_i,
  input  logic [A_WIDTH-1:0] snoop_wr_ptr_i,
  input  logic               snoop_wr_ptr_val_i
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LAST  = RAM_LATENCY - 1;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             cmd_ready, accept, pop, push, acc_hit;

  logic               pipe_vld_q  [RAM_LATENCY];
  ht_command_t        pipe_cmd_q  [RAM_LATENCY];
  logic [B_WIDTH-1:0] pipe_bkt_q  [RAM_LATENCY];
  logic               pipe_fwd_q  [RAM_LATENCY];
  logic [A_WIDTH-1:0] pipe_fptr_q [RAM_LATENCY];
  logic               pipe_fval_q [RAM_LATENCY];
  logic               pipe_fwd_d  [RAM_LATENCY];
  logic [A_WIDTH-1:0] pipe_fptr_d [RAM_LATENCY];
  logic               pipe_fval_d [RAM_LATENCY];

  logic               mem_vld_q  [FIFO_DEPTH];
  ht_command_t        mem_cmd_q  [FIFO_DEPTH];
  logic [B_WIDTH-1:0] mem_bkt_q  [FIFO_DEPTH];
  logic [A_WIDTH-1:0] mem_ptr_q  [FIFO_DEPTH];
  logic               mem_pval_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [A_WIDTH-1:0] push_ptr;
  logic               push_pval;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers reads in flight as well as buffered tasks, so RAM data always has a slot.
  assign cmd_ready = (occ_q < OCC_W'(FIFO_DEPTH));
  assign accept    = hp_if.cmd_valid && cmd_ready && !rst_i;
  assign pop       = hp_if.task_valid && hp_if.task_ready;
  assign acc_hit   = snoop_wr_en_i && (hp_if.bucket == snoop_wr_addr_i);
  assign push      = pipe_vld_q[LAST];

  assign hp_if.cmd_ready  = cmd_ready;
  assign hp_if.task_valid = mem_vld_q[rd_ptr_q];
  assign hp_if.task_data  = {mem_cmd_q[rd_ptr_q], mem_bkt_q[rd_ptr_q],
                             mem_ptr_q[rd_ptr_q], mem_pval_q[rd_ptr_q]};
  assign ht_rd_en_o       = accept;
  assign ht_rd_addr_o     = hp_if.bucket;

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !accept) occ_d = occ_q - 1'b1;
  end

  // Snooped view of the tag pipe; the tail view already covers a write in the push cycle.
  always_comb begin
    for (int i = 0; i < RAM_LATENCY; i++) begin
      pipe_fwd_d[i]  = pipe_fwd_q[i];
      pipe_fptr_d[i] = pipe_fptr_q[i];
      pipe_fval_d[i] = pipe_fval_q[i];
      if (snoop_wr_en_i && pipe_vld_q[i] && (pipe_bkt_q[i] == snoop_wr_addr_i)) begin
        pipe_fwd_d[i]  = 1'b1;
        pipe_fptr_d[i] = snoop_wr_ptr_i;
        pipe_fval_d[i] = snoop_wr_ptr_val_i;
      end
    end
    push_ptr  = pipe_fwd_d[LAST] ? pipe_fptr_d[LAST] : ht_rd_ptr_i;
    push_pval = pipe_fwd_d[LAST] ? pipe_fval_d[LAST] : ht_rd_ptr_val_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_vld_q[i] <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++)  mem_vld_q[j]  <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < RAM_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      if (pop) begin
        mem_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q            <= wrap_inc(rd_ptr_q);
      end
      if (push) begin
        mem_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= wrap_inc(wr_ptr_q);
      end
    end
  end

  // RAM read-during-write returns old data, so a same-cycle write is forwarded at entry.
  always_ff @(posedge clk_i) begin
    pipe_cmd_q[0]  <= hp_if.cmd;
    pipe_bkt_q[0]  <= hp_if.bucket;
    pipe_fwd_q[0]  <= acc_hit;
    pipe_fptr_q[0] <= snoop_wr_ptr_i;
    pipe_fval_q[0] <= snoop_wr_ptr_val_i;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      pipe_cmd_q[i]  <= pipe_cmd_q[i-1];
      pipe_bkt_q[i]  <= pipe_bkt_q[i-1];
      pipe_fwd_q[i]  <= pipe_fwd_d[i-1];
      pipe_fptr_q[i] <= pipe_fptr_d[i-1];
      pipe_fval_q[i] <= pipe_fval_d[i-1];
    end
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      if (snoop_wr_en_i && mem_vld_q[j] && (mem_bkt_q[j] == snoop_wr_addr_i) &&
          !(pop && (PTR_W'(j) == rd_ptr_q))) begin
        mem_ptr_q[j]  <= snoop_wr_ptr_i;
        mem_pval_q[j] <= snoop_wr_ptr_val_i;
      end
    end
    if (push) begin
      mem_cmd_q[wr_ptr_q]  <= pipe_cmd_q[LAST];
      mem_bkt_q[wr_ptr_q]  <= pipe_bkt_q[LAST];
      mem_ptr_q[wr_ptr_q]  <= push_ptr;
      mem_pval_q[wr_ptr_q] <= push_pval;
    end
  end
endmodule

// File: tb/tb_head_ptr_fetch.sv
// Bench for head_ptr_fetch: latency-2 head-table RAM model, scoreboard queue
// of expected tasks, table-driven streaming plus hand-written corner cases.
module tb_head_ptr_fetch;
  import head_ptr_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_ptr;
  logic       rd_ptr_val;
  logic       snoop_en;
  logic [7:0] snoop_addr;
  logic [7:0] snoop_ptr;
  logic       snoop_val;
  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_ptr;
  logic       pre_val;

  head_ptr_fetch_if hp_if();

  head_ptr_fetch #(
    .RAM_LATENCY(2), .FIFO_DEPTH(4),
    .A_WIDTH(TABLE_ADDR_WIDTH), .B_WIDTH(BUCKET_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hp_if(hp_if),
    .ht_rd_addr_o(rd_addr), .ht_rd_en_o(rd_en),
    .ht_rd_ptr_i(rd_ptr), .ht_rd_ptr_val_i(rd_ptr_val),
    .snoop_wr_en_i(snoop_en), .snoop_wr_addr_i(snoop_addr),
    .snoop_wr_ptr_i(snoop_ptr), .snoop_wr_ptr_val_i(snoop_val)
  );

  always #5 clk = ~clk;

  // Head-table RAM: read data appears two cycles after the strobe; a read in
  // the same cycle as a write returns the old contents.
  logic [7:0] ram_ptr [256];
  logic       ram_val [256];
  logic [8:0] rd_pipe [2];
  always @(posedge clk) begin
    rd_pipe[0] <= rd_en ? {ram_val[rd_addr], ram_ptr[rd_addr]} : 9'h155;
    rd_pipe[1] <= rd_pipe[0];
    if (snoop_en) begin
      ram_ptr[snoop_addr] <= snoop_ptr;
      ram_val[snoop_addr] <= snoop_val;
    end
    if (pre_en) begin
      ram_ptr[pre_addr] <= pre_ptr;
      ram_val[pre_addr] <= pre_val;
    end
  end
  assign rd_ptr     = rd_pipe[1][7:0];
  assign rd_ptr_val = rd_pipe[1][8];

  int        n_vec = 0;
  int        n_err = 0;
  ht_pdata_t exp_q[$];
  ht_pdata_t mon_exp;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic ht_command_t mkcmd(input logic [15:0] key);
    ht_command_t c;
    c.opcode = key[1:0];
    c.key    = key;
    c.value  = ~key;
    return c;
  endfunction

  function automatic ht_pdata_t mk(input logic [15:0] key, input logic [7:0] b,
                                   input logic [7:0] p, input logic v);
    return {mkcmd(key), b, p, v};
  endfunction

  // Scoreboard: every accepted task must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && hp_if.task_valid && hp_if.task_ready) begin
      chk("task_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("task_data", 64'(hp_if.task_data), 64'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_load(input logic [7:0] a, input logic [7:0] p, input logic v);
    pre_en = 1'b1; pre_addr = a; pre_ptr = p; pre_val = v;
    step();
    pre_en = 1'b0;
  endtask

  task automatic drive_cmd(input logic [7:0] b, input logic [15:0] key);
    hp_if.cmd       = mkcmd(key);
    hp_if.bucket    = b;
    hp_if.cmd_valid = 1'b1;
  endtask

  task automatic snoop(input logic en, input logic [7:0] a, input logic [7:0] p, input logic v);
    snoop_en = en; snoop_addr = a; snoop_ptr = p; snoop_val = v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hp_if.task_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  bucket;
    logic [7:0]  ram_ptr;
    logic        ram_val;
    logic [15:0] key;
    logic [7:0]  exp_ptr;
    logic        exp_val;
  } vec_t;
  vec_t vt[8];
  logic [7:0] s3b[6];
  int k;

  initial begin
    vt[0] = '{8'h10, 8'h21, 1'b1, 16'hA000, 8'h21, 1'b1};
    vt[1] = '{8'h11, 8'hFF, 1'b0, 16'hA001, 8'hFF, 1'b0};
    vt[2] = '{8'h12, 8'h00, 1'b1, 16'hA002, 8'h00, 1'b1};
    vt[3] = '{8'hFF, 8'h5A, 1'b1, 16'hA003, 8'h5A, 1'b1};
    vt[4] = '{8'h00, 8'hC3, 1'b0, 16'hA004, 8'hC3, 1'b0};
    vt[5] = '{8'h80, 8'h7E, 1'b1, 16'hA005, 8'h7E, 1'b1};
    vt[6] = '{8'h13, 8'h01, 1'b1, 16'hA006, 8'h01, 1'b1};
    vt[7] = '{8'h14, 8'hA5, 1'b0, 16'hA007, 8'hA5, 1'b0};
    s3b   = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};

    rst = 1'b1;
    hp_if.cmd = '0; hp_if.bucket = '0; hp_if.cmd_valid = 1'b0; hp_if.task_ready = 1'b1;
    snoop(1'b0, 8'h0, 8'h0, 1'b0);
    pre_en = 1'b0; pre_addr = '0; pre_ptr = '0; pre_val = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_task_valid", 64'(hp_if.task_valid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(hp_if.cmd_ready), 64'd1);
    step();

    // Single command, latency to task
    ram_load(8'h05, 8'h12, 1'b1);
    drive_cmd(8'h05, 16'h0105);
    @(negedge clk);
    chk("s1_rd_en", 64'(rd_en), 64'd1);
    chk("s1_rd_addr", 64'(rd_addr), 64'h05);
    exp_q.push_back(mk(16'h0105, 8'h05, 8'h12, 1'b1));
    step();
    hp_if.cmd_valid = 1'b0;
    @(negedge clk); chk("s1_lat_t1", 64'(hp_if.task_valid), 64'd0);
    @(negedge clk); chk("s1_lat_t2", 64'(hp_if.task_valid), 64'd0);
    @(negedge clk); chk("s1_lat_t3", 64'(hp_if.task_valid), 64'd1);
    chk("s1_head_ptr", 64'(hp_if.task_data.head_ptr), 64'h12);
    step();
    drain(20);

    // Back-to-back table vectors at full throughput
    for (int i = 0; i < 8; i++) ram_load(vt[i].bucket, vt[i].ram_ptr, vt[i].ram_val);
    for (int i = 0; i < 8; i++) begin
      drive_cmd(vt[i].bucket, vt[i].key);
      @(negedge clk);
      chk("s2_cmd_ready", 64'(hp_if.cmd_ready), 64'd1);
      chk("s2_rd_en", 64'(rd_en), 64'd1);
      exp_q.push_back(mk(vt[i].key, vt[i].bucket, vt[i].exp_ptr, vt[i].exp_val));
      step();
    end
    hp_if.cmd_valid = 1'b0;
    drain(20);

    // Backpressure: credit limit of four, then resume
    for (int i = 0; i < 6; i++) ram_load(s3b[i], 8'h60 + 8'(i), 1'b1);
    hp_if.task_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cmd(s3b[k], 16'h3000 + 16'(k));
      @(negedge clk);
      if (hp_if.cmd_ready) begin
        exp_q.push_back(mk(16'h3000 + 16'(k), s3b[k], 8'h60 + 8'(k), 1'b1));
        k++;
      end
      step();
    end
    chk("s3_accepted", 64'(k), 64'd4);
    @(negedge clk);
    chk("s3_ready_low", 64'(hp_if.cmd_ready), 64'd0);
    step();
    hp_if.task_ready = 1'b1;
    for (int c = 0; c < 30 && k < 6; c++) begin
      drive_cmd(s3b[k], 16'h3000 + 16'(k));
      @(negedge clk);
      if (hp_if.cmd_ready) begin
        exp_q.push_back(mk(16'h3000 + 16'(k), s3b[k], 8'h60 + 8'(k), 1'b1));
        k++;
      end
      step();
    end
    hp_if.cmd_valid = 1'b0;
    chk("s3_resumed", 64'(k), 64'd6);
    drain(20);

    // Snoop forwarding into the tag pipe
    ram_load(8'h07, 8'h00, 1'b0);
    ram_load(8'h09, 8'h44, 1'b1);
    ram_load(8'h0B, 8'h55, 1'b1);
    drive_cmd(8'h07, 16'h4007);
    exp_q.push_back(mk(16'h4007, 8'h07, 8'h3A, 1'b1));
    step();
    hp_if.cmd_valid = 1'b0;
    snoop(1'b1, 8'h07, 8'h3A, 1'b1);
    step();
    snoop(1'b0, 8'h00, 8'h00, 1'b0);
    drive_cmd(8'h09, 16'h4009);
    snoop(1'b1, 8'h09, 8'h66, 1'b1);
    @(negedge clk);
    chk("s4_rdw_accept", 64'(rd_en), 64'd1);
    exp_q.push_back(mk(16'h4009, 8'h09, 8'h66, 1'b1));
    step();
    hp_if.cmd_valid = 1'b0;
    snoop(1'b0, 8'h00, 8'h00, 1'b0);
    drive_cmd(8'h0B, 16'h400B);
    exp_q.push_back(mk(16'h400B, 8'h0B, 8'h77, 1'b0));
    step();
    hp_if.cmd_valid = 1'b0;
    step();
    snoop(1'b1, 8'h0B, 8'h77, 1'b0);
    step();
    snoop(1'b0, 8'h00, 8'h00, 1'b0);
    drain(20);

    // Snoop into stalled FIFO entries
    ram_load(8'h03, 8'h33, 1'b1);
    hp_if.task_ready = 1'b0;
    drive_cmd(8'h07, 16'h5007);
    exp_q.push_back(mk(16'h5007, 8'h07, 8'h11, 1'b1));
    step();
    drive_cmd(8'h03, 16'h5003);
    exp_q.push_back(mk(16'h5003, 8'h03, 8'h33, 1'b1));
    step();
    hp_if.cmd_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("s5_before_snoop", 64'(hp_if.task_data.head_ptr), 64'h3A);
    step();
    snoop(1'b1, 8'h07, 8'h11, 1'b1);
    step();
    snoop(1'b1, 8'h08, 8'h22, 1'b1);
    step();
    snoop(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("s5_fwd_head", 64'(hp_if.task_data), 64'(mk(16'h5007, 8'h07, 8'h11, 1'b1)));
    step();
    @(negedge clk);
    chk("s5_hold_valid", 64'(hp_if.task_valid), 64'd1);
    chk("s5_hold_data", 64'(hp_if.task_data), 64'(mk(16'h5007, 8'h07, 8'h11, 1'b1)));
    step();
    hp_if.task_ready = 1'b1;
    drain(20);

    // Reset with tasks pending
    ram_load(8'h01, 8'h91, 1'b1);
    ram_load(8'h02, 8'h92, 1'b1);
    hp_if.task_ready = 1'b0;
    drive_cmd(8'h01, 16'h6001); step();
    drive_cmd(8'h02, 16'h6002); step();
    drive_cmd(8'h03, 16'h6003); step();
    hp_if.cmd_valid = 1'b0;
    step();
    @(negedge clk);
    chk("s6_pending", 64'(hp_if.task_valid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("s6_rst_immediate", 64'(hp_if.task_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hp_if.task_ready = 1'b1;
    @(negedge clk);
    chk("s6_cmd_ready", 64'(hp_if.cmd_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s6_no_stale", 64'(hp_if.task_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
